// File: rtl/spi_slave_if.sv
// Purpose : bundles the SPI pins and the fabric word handshake of spi_slave into one port.
// Latency : none, wires only.
// Backpressure : none; tx uses a valid/accept pulse and rx uses a valid level cleared by rx_ack.
// Ports   : ss/sck/mosi/miso/miso_oe (SPI pins), tx_data/tx_valid/tx_accept (word to send),
//           rx_data/rx_valid/rx_ack (received word), frame_err/rx_overrun (status pulses).
// Modports: slave = the responder block, master = the side that drives the pins and the fabric.
interface spi_slave_if #(
    parameter int WIDTH = 16
);
    logic             ss;
    logic             sck;
    logic             mosi;
    logic             miso;
    logic             miso_oe;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_accept;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ack;
    logic             frame_err;
    logic             rx_overrun;

    modport slave (
        input  ss, sck, mosi, tx_data, tx_valid, rx_ack,
        output miso, miso_oe, tx_accept, rx_data, rx_valid, frame_err, rx_overrun
    );

    modport master (
        output ss, sck, mosi, tx_data, tx_valid, rx_ack,
        input  miso, miso_oe, tx_accept, rx_data, rx_valid, frame_err, rx_overrun
    );
endinterface

// File: rtl/spi_slave.sv
// Purpose : SPI mode-0 responder (LSB first, SS#-framed) on clk; pins are synchronised, never used as clocks.
// Latency : rx word visible 1 clk after the final SCK rise is detected (SYNC_STAGES+1 clks after the pin edge).
// Backpressure : none on the pins; an unread rx word is overwritten, or kept when SPI_SLAVE_OVERRUN_EN is defined.
// Ports   : clk, reset_n (async, active low), bus (spi_slave_if.slave).
// Params  : WIDTH bits per frame, SYNC_STAGES synchroniser depth (2 or 3), IDLE_FILL word sent with no tx word.
// Macro   : SPI_SLAVE_OVERRUN_EN - keep the unread word and pulse rx_overrun instead of overwriting.
module spi_slave #(
    parameter int               WIDTH       = 16,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] IDLE_FILL   = {WIDTH{1'b1}}
) (
    input  logic       clk,
    input  logic       reset_n,
    spi_slave_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Input synchronisers; SS# presets high and SCK low so reset never looks like a frame start.
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   ss_q;
    logic                   sck_q;
    logic                   ss_s;
    logic                   sck_s;
    logic                   mosi_s;
    logic                   ss_fall;
    logic                   ss_rise;
    logic                   sck_rise;
    logic                   sck_fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ss_sync   <= '1;
            sck_sync  <= '0;
            mosi_sync <= '0;
            ss_q      <= 1'b1;
            sck_q     <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.ss};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            ss_q      <= ss_s;
            sck_q     <= sck_s;
        end
    end

    assign ss_s     = ss_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign ss_fall  = ss_q & ~ss_s;
    assign ss_rise  = ~ss_q & ss_s;
    assign sck_rise = ~sck_q & sck_s;
    assign sck_fall = sck_q & ~sck_s;

    // Datapath registers
    logic [WIDTH-1:0] rx_sh;
    logic [WIDTH-1:0] tx_sh;
    logic [WIDTH-1:0] rx_nxt;
    logic [WIDTH-1:0] ld_word;
    logic [CW-1:0]    cnt;
    logic             miso_q;
    logic             tx_accept_q;
    logic [WIDTH-1:0] rx_data_q;
    logic             rx_valid_q;
    logic             frame_err_q;

    // Control strobes from the FSM
    logic load;
    logic rx_shift;
    logic tx_shift;
    logic commit;
    logic abort;

    assign rx_nxt  = {mosi_s, rx_sh[WIDTH-1:1]};
    assign ld_word = bus.tx_valid ? bus.tx_data : IDLE_FILL;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        rx_shift  = 1'b0;
        tx_shift  = 1'b0;
        commit    = 1'b0;
        abort     = 1'b0;
        unique case (state)
            IDLE: begin
                if (ss_fall) begin
                    // A rise seen with the SS# fall is bit 0 of this frame.
                    load      = 1'b1;
                    rx_shift  = sck_rise;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (sck_rise && cnt == CW'(WIDTH - 1)) begin
                    // The last bit arrived, so a simultaneous SS# rise is a clean end, not an abort.
                    rx_shift  = 1'b1;
                    commit    = 1'b1;
                    state_nxt = ss_rise ? IDLE : DONE;
                end else if (ss_rise) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    rx_shift  = sck_rise;
                    tx_shift  = sck_fall;
                end
            end
            DONE: begin
                if (ss_rise) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic rx_overrun_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_sh        <= '0;
            tx_sh        <= '1;
            cnt          <= '0;
            miso_q       <= 1'b1;
            tx_accept_q  <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
            rx_overrun_q <= 1'b0;
`endif
        end else begin
            tx_accept_q <= load & bus.tx_valid;
            frame_err_q <= abort;
`ifdef SPI_SLAVE_OVERRUN_EN
            rx_overrun_q <= 1'b0;
`endif

            if (load) begin
                cnt <= rx_shift ? CW'(1) : '0;
            end else if (rx_shift) begin
                cnt <= cnt + 1'b1;
            end

            if (rx_shift) begin
                rx_sh <= rx_nxt;
            end

            if (load) begin
                tx_sh <= ld_word;
            end else if (tx_shift) begin
                tx_sh <= {1'b1, tx_sh[WIDTH-1:1]};
            end

            // MISO shows bit 0 straight away on load, the next bit after each fall,
            // and idles high once the frame has ended or been abandoned.
            if (load) begin
                miso_q <= ld_word[0];
            end else if (tx_shift) begin
                miso_q <= tx_sh[1];
            end else if (commit || abort) begin
                miso_q <= 1'b1;
            end

            // A completing frame beats a simultaneous rx_ack.
            if (commit) begin
`ifdef SPI_SLAVE_OVERRUN_EN
                if (rx_valid_q && !bus.rx_ack) begin
                    rx_overrun_q <= 1'b1;
                end else begin
                    rx_data_q  <= rx_nxt;
                    rx_valid_q <= 1'b1;
                end
`else
                rx_data_q  <= rx_nxt;
                rx_valid_q <= 1'b1;
`endif
            end else if (bus.rx_ack) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign bus.miso      = miso_q;
    assign bus.miso_oe   = ~ss_s;
    assign bus.tx_accept = tx_accept_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
`ifdef SPI_SLAVE_OVERRUN_EN
    assign bus.rx_overrun = rx_overrun_q;
`else
    assign bus.rx_overrun = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// Purpose : drives spi_slave as an SPI mode-0 master plus fabric, checking against a frame-level model.
// Latency : n/a.
// Backpressure : n/a.
`timescale 1ns/1ps
module tb_spi_slave;
    localparam int WIDTH = 16;
    localparam int SYNC  = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    spi_slave_if #(.WIDTH(WIDTH)) bus();

    spi_slave #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC),
        .IDLE_FILL  (16'hFFFF)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: the word the fabric should see and whether it is unread.
    logic [WIDTH-1:0] m_data  = '0;
    logic             m_valid = 1'b0;
    bit               chk_en  = 1'b0;
    int               n_acc = 0;
    int               n_ferr = 0;
    int               n_ovr = 0;
    int               ss_stable = 0;
    logic             ss_prev = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Per-cycle compare process, sampling on the falling edge.
    always @(negedge clk) begin
        if (bus.tx_accept === 1'b1)  n_acc++;
        if (bus.frame_err === 1'b1)  n_ferr++;
        if (bus.rx_overrun === 1'b1) n_ovr++;
        if (!reset_n || bus.ss !== ss_prev) ss_stable = 0;
        else ss_stable++;
        ss_prev = bus.ss;
        if (ss_stable >= SYNC + 2) begin
            check("miso_oe", {31'd0, bus.miso_oe}, {31'd0, ~bus.ss});
            if (bus.ss) check("miso_idle", {31'd0, bus.miso}, 32'd1);
        end
        if (chk_en) begin
            check("rx_data", {16'd0, bus.rx_data}, {16'd0, m_data});
            check("rx_valid", {31'd0, bus.rx_valid}, {31'd0, m_valid});
        end
    end

    // One SS# window with nb SCK cycles of half-period h clks; simul puts the first
    // SCK rise on the SS# fall. Expectations come from the frame rules, not cycle timing.
    task automatic run_frame(input logic [31:0] mw, input int nb, input int h, input bit tv,
                             input logic [WIDTH-1:0] td, input bit simul, output logic [31:0] cap);
        logic [31:0] exp_cap;
        logic [31:0] mask;
        bit          done;
        bit          ovr;
        cap = '0;
        chk_en = 1'b0;
        bus.tx_valid = tv;
        bus.tx_data  = td;
        n_acc = 0;
        n_ferr = 0;
        n_ovr = 0;
        wait_clk(2);
        bus.mosi = mw[0];
        bus.ss   = 1'b0;
        if (!simul) wait_clk(h + 1);
        for (int i = 0; i < nb; i++) begin
            cap[i]  = bus.miso;
            bus.sck = 1'b1;
            wait_clk(h);
            bus.sck  = 1'b0;
            bus.mosi = (i < 31) ? mw[i+1] : 1'b0;
            wait_clk(h);
        end
        bus.ss = 1'b1;
        wait_clk(SYNC + 4);
        bus.tx_valid = 1'b0;

        done = (nb >= WIDTH);
        exp_cap = '1;
        exp_cap[WIDTH-1:0] = tv ? td : 16'hFFFF;
        mask = (nb >= 32) ? 32'hFFFF_FFFF : ((32'd1 << nb) - 32'd1);
        if (simul) mask[0] = 1'b0;
        check("miso_bits", cap & mask, exp_cap & mask);
        check("tx_accept_cnt", n_acc, {31'd0, tv});
        check("frame_err_cnt", n_ferr, {31'd0, ~done});
        ovr = 1'b0;
        if (done) begin
`ifdef SPI_SLAVE_OVERRUN_EN
            if (m_valid) begin
                ovr = 1'b1;
            end else begin
                m_data  = mw[WIDTH-1:0];
                m_valid = 1'b1;
            end
`else
            m_data  = mw[WIDTH-1:0];
            m_valid = 1'b1;
`endif
        end
        check("rx_overrun_cnt", n_ovr, {31'd0, ovr});
        chk_en = 1'b1;
    endtask

    task automatic do_ack();
        bus.rx_ack = 1'b1;
        wait_clk(1);
        bus.rx_ack = 1'b0;
        m_valid = 1'b0;
        check("ack_clear", {31'd0, bus.rx_valid}, 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_miso", {31'd0, bus.miso}, 32'd1);
        check("rst_miso_oe", {31'd0, bus.miso_oe}, 32'd0);
        check("rst_tx_accept", {31'd0, bus.tx_accept}, 32'd0);
        check("rst_rx_data", {16'd0, bus.rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
        check("rst_rx_overrun", {31'd0, bus.rx_overrun}, 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]      cap;
        logic [31:0]      w;
        logic [WIDTH-1:0] td;
        logic [WIDTH-1:0] ovr_exp;
        int               nb;
        int               h;
        bit               tv;
        bit               sim1;

        bus.ss = 1'b1;
        bus.sck = 1'b0;
        bus.mosi = 1'b0;
        bus.tx_data = '0;
        bus.tx_valid = 1'b0;
        bus.rx_ack = 1'b0;
        reset_n = 1'b0;
        wait_clk(4);
        check_reset_outputs();
        reset_n = 1'b1;
        wait_clk(3);
        chk_en = 1'b1;

        // Put a word in rx_data, then reset in the middle of the next frame.
        run_frame(32'h0000_BEEF, 16, 3, 1'b1, 16'h1357, 1'b0, cap);
        check("pre_rst_rx", {16'd0, bus.rx_data}, 32'h0000_BEEF);
        chk_en = 1'b0;
        bus.ss = 1'b0;
        bus.mosi = 1'b1;
        wait_clk(4);
        for (int i = 0; i < 5; i++) begin
            bus.sck = 1'b1;
            wait_clk(3);
            bus.sck = 1'b0;
            wait_clk(3);
        end
        n_acc = 0;
        n_ferr = 0;
        n_ovr = 0;
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        bus.ss = 1'b1;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(5);
        check("rst_no_pulses", n_acc + n_ferr + n_ovr, 32'd0);
        m_data = '0;
        m_valid = 1'b0;
        chk_en = 1'b1;
        run_frame(32'h0000_1234, 16, 3, 1'b0, 16'h0, 1'b0, cap);
        check("post_rst_rx", {16'd0, bus.rx_data}, 32'h0000_1234);
        check("post_rst_valid", {31'd0, bus.rx_valid}, 32'd1);

        // Full duplex, SCK = clk/6.
        do_ack();
        run_frame(32'h0000_3C81, 16, 3, 1'b1, 16'hA55A, 1'b0, cap);
        check("dup_miso", {16'd0, cap[15:0]}, 32'h0000_A55A);
        check("dup_accept", n_acc, 32'd1);
        check("dup_rx", {16'd0, bus.rx_data}, 32'h0000_3C81);
        check("dup_valid", {31'd0, bus.rx_valid}, 32'd1);

        // No tx word pending.
        do_ack();
        run_frame(32'h0000_00FF, 16, 4, 1'b0, 16'h1234, 1'b0, cap);
        check("idle_miso", {16'd0, cap[15:0]}, 32'h0000_FFFF);
        check("idle_accept", n_acc, 32'd0);
        check("idle_rx", {16'd0, bus.rx_data}, 32'h0000_00FF);

        // Abort after 9 rises leaves the unread word alone.
        run_frame(32'h0000_5555, 9, 3, 1'b0, 16'h0, 1'b0, cap);
        check("abort_ferr", n_ferr, 32'd1);
        check("abort_rx", {16'd0, bus.rx_data}, 32'h0000_00FF);
        check("abort_valid", {31'd0, bus.rx_valid}, 32'd1);
        do_ack();
        run_frame(32'h0000_0001, 16, 3, 1'b0, 16'h0, 1'b0, cap);
        check("after_abort_rx", {16'd0, bus.rx_data}, 32'h0000_0001);

        // Two frames without rx_ack.
        do_ack();
        run_frame(32'h0000_1111, 16, 3, 1'b0, 16'h0, 1'b0, cap);
        run_frame(32'h0000_2222, 16, 3, 1'b0, 16'h0, 1'b0, cap);
`ifdef SPI_SLAVE_OVERRUN_EN
        ovr_exp = 16'h1111;
        check("ovr_pulse", n_ovr, 32'd1);
`else
        ovr_exp = 16'h2222;
        check("ovr_pulse", n_ovr, 32'd0);
`endif
        check("ovr_rx", {16'd0, bus.rx_data}, {16'd0, ovr_exp});

        // 20 SCK cycles in one window.
        do_ack();
        run_frame(32'h000A_5A3C, 20, 3, 1'b1, 16'h0F0F, 1'b0, cap);
        check("extra_rx", {16'd0, bus.rx_data}, 32'h0000_5A3C);
        check("extra_miso_lo", {16'd0, cap[15:0]}, 32'h0000_0F0F);
        check("extra_miso_hi", {28'd0, cap[19:16]}, 32'h0000_000F);
        check("extra_valid_before_ack", {31'd0, bus.rx_valid}, 32'd1);
        do_ack();

        // SS# fall and first SCK rise land together.
        run_frame(32'h0000_C3A5, 16, 3, 1'b1, 16'h6E2B, 1'b1, cap);
        check("simul_rx", {16'd0, bus.rx_data}, 32'h0000_C3A5);

        // Randomized frames.
        for (int k = 0; k < 40; k++) begin
            w    = $urandom;
            nb   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 16;
            h    = int'($urandom_range(SYNC + 1, SYNC + 3));
            tv   = 1'($urandom_range(0, 1));
            td   = WIDTH'($urandom);
            sim1 = ($urandom_range(0, 7) == 0);
            if (m_valid && $urandom_range(0, 1) == 1) do_ack();
            run_frame(w, nb, h, tv, td, sim1, cap);
        end

        wait_clk(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
